i2c_master_arbiter: RTL and testbench

//  Shares one i2c_master among NREQ requesters. Each requester issues a single-byte I2C command (7-bit addr, rw, wdata).

---
 rtl/i2c_master_arbiter_pkg.sv | 20 ++
 rtl/i2c_master_arbiter_rr_arbiter.sv | 33 +++
 rtl/i2c_master_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types for the i2c_master arbiter: FSM state encoding and the latched command record.
package i2c_master_arbiter_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wdata;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping, as one-hot plus index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    logic [IDXW-1:0] w_k;

    // Scan from the pointer position; the first hit wins and later hits are masked by o_valid.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = IDXW'((int'(i_ptr) + i) % NREQ);
            if (!o_valid && i_req[w_k]) begin
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                o_valid      = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master among NREQ single-byte command requesters: round-robin grant,
// command latch, completion/timeout handling and an enforced idle gap after every transaction.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 100,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_done,
    output logic [NREQ-1:0]        rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   busy,
    output logic                   m_i2c_start,
    output logic [ADDR_W-1:0]      m_addr,
    output logic                   m_rw,
    output logic [DATA_W-1:0]      m_data_send,
    input  logic                   m_i2c_done,
    input  logic [DATA_W-1:0]      m_data_recv,
    input  logic                   m_data_recv_done
);

    localparam int IDXW = $clog2(NREQ);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int GW   = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]   GLAST    = GW'(GAP_CYC - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_gnt_idx;
    logic [IDXW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]   w_gnt_oh;
    logic              w_gnt_valid;
    logic              w_accept;
    i2c_cmd_t          r_cmd;
    i2c_cmd_t          w_req_cmd;
    logic [TW-1:0]     r_tcnt;
    logic [GW-1:0]     r_gcnt;
    logic              r_done_q;
    logic              w_done_rise;
    logic              w_timeout;
    logic [DATA_W-1:0] r_rdata_q;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [NREQ-1:0]   r_rsp_done;
    logic [NREQ-1:0]   r_rsp_err;
    logic [NREQ-1:0]   w_own;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    assign w_req_cmd   = {req_addr[ADDR_W*w_gnt_idx +: ADDR_W], req_rw[w_gnt_idx],
                          req_wdata[DATA_W*w_gnt_idx +: DATA_W]};
    assign w_accept    = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_own       = NREQ'(1) << r_gnt_idx;
    // Completion is an edge only; a level already high when BUSY starts is not a completion.
    assign w_done_rise = (r_state == ST_BUSY) && m_i2c_done && !r_done_q;
    assign w_timeout   = (r_state == ST_BUSY) && (r_tcnt == TLAST) && !w_done_rise;

    assign m_addr      = r_cmd.addr;
    assign m_rw        = r_cmd.rw;
    assign m_data_send = r_cmd.wdata;
    assign rsp_done    = r_rsp_done;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and decoded outputs; req_ready is withheld while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        m_i2c_start = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_gnt_valid && arstn) begin
                    req_ready   = w_gnt_oh;
                    w_state_nxt = ST_START;
                end else if (w_gnt_valid) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                m_i2c_start = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_done_rise || w_timeout) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (r_gcnt == GLAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: latch the winner's command and move the pointer past it.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_cmd     <= '0;
        end else if (w_accept) begin
            r_ptr     <= (w_gnt_idx == IDX_LAST) ? '0 : w_gnt_idx + IDXW'(1);
            r_gnt_idx <= w_gnt_idx;
            r_cmd     <= w_req_cmd;
        end else begin
            r_ptr     <= r_ptr;
            r_gnt_idx <= r_gnt_idx;
            r_cmd     <= r_cmd;
        end
    end

    // Timeout counter runs in BUSY, gap counter in GAP; each clears on entry to its state.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_tcnt <= '0;
            r_gcnt <= '0;
        end else begin
            if (r_state == ST_START) begin
                r_tcnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_tcnt <= r_tcnt + TW'(1);
            end else begin
                r_tcnt <= r_tcnt;
            end
            if (r_state == ST_BUSY) begin
                r_gcnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gcnt <= r_gcnt + GW'(1);
            end else begin
                r_gcnt <= r_gcnt;
            end
        end
    end

    // Done edge history and the most recent byte captured while BUSY.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_done_q  <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_done_q <= m_i2c_done;
            if ((r_state == ST_BUSY) && m_data_recv_done) begin
                r_rdata_q <= m_data_recv;
            end else begin
                r_rdata_q <= r_rdata_q;
            end
        end
    end

    // Response pulses to the owning requester; a read completing in the capture cycle forwards the live byte.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_rsp_done  <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
        end else if (w_done_rise) begin
            r_rsp_done <= w_own;
            r_rsp_err  <= '0;
            if (r_cmd.rw) begin
                r_rsp_rdata <= m_data_recv_done ? m_data_recv : r_rdata_q;
            end else begin
                r_rsp_rdata <= r_rsp_rdata;
            end
        end else if (w_timeout) begin
            r_rsp_done  <= w_own;
            r_rsp_err   <= w_own;
            r_rsp_rdata <= r_rsp_rdata;
        end else begin
            r_rsp_done  <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= r_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed and randomized bench for i2c_master_arbiter; the i2c_master side is played by the bench.
module tb_i2c_master_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 6;
    localparam int TMO  = 60;

    logic                clk = 1'b0;
    logic                arstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_rw;
    logic [7*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_done;
    logic [NREQ-1:0]     rsp_err;
    logic [7:0]          rsp_rdata;
    logic                busy;
    logic                m_i2c_start;
    logic [6:0]          m_addr;
    logic                m_rw;
    logic [7:0]          m_data_send;
    logic                m_i2c_done;
    logic [7:0]          m_data_recv;
    logic                m_data_recv_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending commands, next round-robin start, and the visible read byte.
    logic [6:0] c_addr  [NREQ];
    logic       c_rw    [NREQ];
    logic [7:0] c_wdata [NREQ];
    int         exp_ptr = 0;
    logic [7:0] exp_rdata = 8'h00;

    always #10 clk = ~clk;

    i2c_master_arbiter #(
        .NREQ        (NREQ),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk              (clk),
        .arstn            (arstn),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_rw           (req_rw),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_done         (rsp_done),
        .rsp_err          (rsp_err),
        .rsp_rdata        (rsp_rdata),
        .busy             (busy),
        .m_i2c_start      (m_i2c_start),
        .m_addr           (m_addr),
        .m_rw             (m_rw),
        .m_data_send      (m_data_send),
        .m_i2c_done       (m_i2c_done),
        .m_data_recv      (m_data_recv),
        .m_data_recv_done (m_data_recv_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [6:0] a, input logic r, input logic [7:0] w);
        c_addr[i]            = a;
        c_rw[i]              = r;
        c_wdata[i]           = w;
        req_addr[7*i +: 7]   = a;
        req_rw[i]            = r;
        req_wdata[8*i +: 8]  = w;
        req_valid[i]         = 1'b1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ] == 1'b1) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tg);
        check({tg, "_outs_a"}, {8'h00, req_ready, rsp_done, rsp_err, rsp_rdata, busy, m_i2c_start, 2'b00},
              32'h0);
        check({tg, "_outs_b"}, {16'h0000, m_addr, m_rw, m_data_send}, 32'h0);
    endtask

    // One full transaction: grant, start, completion at BUSY offset lat (>=TMO means none), gap.
    task automatic do_txn(input string tg, input int lat, input bit pre_high, input int rd_off,
                          input logic [7:0] rbyte, input bit repost, input int rst_at);
        int g;
        int last;
        int n;
        bit got;
        bit early;
        logic [6:0] ea;
        logic       er;
        logic [7:0] ew;
        got = 1'b0;
        for (int k = 0; k < GAP + 4; k++) begin
            #1;
            if (req_ready !== '0) got = 1'b1;
            if (got) break;
            tick();
        end
        check({tg, "_grant_seen"}, 32'(got), 32'd1);
        if (!got) return;
        g = rr_pick(req_valid, exp_ptr);
        check({tg, "_req_ready"}, 32'(req_ready), 32'(1 << g));
        check({tg, "_idle_busy"}, 32'(busy), 32'd0);
        ea = c_addr[g];
        er = c_rw[g];
        ew = c_wdata[g];
        exp_ptr = (g + 1) % NREQ;
        if (pre_high) m_i2c_done = 1'b1;
        tick();
        if (repost) begin
            post(g, 7'($urandom), 1'($urandom), 8'($urandom));
        end else begin
            req_valid[g]        = 1'b0;
            req_addr[7*g +: 7]  = 7'($urandom);
            req_rw[g]           = ~req_rw[g];
            req_wdata[8*g +: 8] = 8'($urandom);
        end
        #1;
        check({tg, "_start"}, 32'(m_i2c_start), 32'd1);
        check({tg, "_cmd"}, 32'({m_addr, m_rw, m_data_send}), 32'({ea, er, ew}));
        tick();
        check({tg, "_start_pulse"}, 32'(m_i2c_start), 32'd0);
        last  = (lat < TMO) ? lat : TMO - 1;
        early = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (rst_at == k) begin
                arstn = 1'b0;
                tick();
                arstn = 1'b1;
                m_i2c_done = 1'b0;
                m_data_recv_done = 1'b0;
                #1;
                check_quiet({tg, "_after_rst"});
                exp_ptr   = 0;
                exp_rdata = 8'h00;
                for (int j = 0; j < TMO + GAP; j++) begin
                    if (rsp_done !== '0) early = 1'b1;
                    tick();
                end
                check({tg, "_no_rsp_after_rst"}, 32'(early), 32'd0);
                return;
            end
            if (pre_high && k == 2) m_i2c_done = 1'b0;
            if (er && k == rd_off) begin
                m_data_recv_done = 1'b1;
                m_data_recv      = rbyte;
            end
            if (k == lat) m_i2c_done = 1'b1;
            if (rsp_done !== '0) early = 1'b1;
            tick();
            m_data_recv_done = 1'b0;
        end
        check({tg, "_no_early_rsp"}, 32'(early), 32'd0);
        check({tg, "_rsp_done"}, 32'(rsp_done), 32'(1 << g));
        if (lat < TMO) begin
            check({tg, "_rsp_err"}, 32'(rsp_err), 32'd0);
            if (er) exp_rdata = rbyte;
        end else begin
            check({tg, "_rsp_err"}, 32'(rsp_err), 32'(1 << g));
            m_i2c_done = 1'b1;
        end
        check({tg, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        n = 1;
        tick();
        check({tg, "_rsp_pulse"}, 32'(rsp_done), 32'd0);
        m_i2c_done = 1'b0;
        while (busy === 1'b1 && n < GAP + 5) begin
            n++;
            tick();
        end
        check({tg, "_gap_len"}, 32'(n), 32'(GAP));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sel;
        arstn            = 1'b0;
        req_valid        = '0;
        req_rw           = '0;
        req_addr         = '0;
        req_wdata        = '0;
        m_i2c_done       = 1'b0;
        m_data_recv      = 8'h00;
        m_data_recv_done = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c_addr[i]  = 7'h00;
            c_rw[i]    = 1'b0;
            c_wdata[i] = 8'h00;
        end
        repeat (3) tick();
        check_quiet("reset");
        arstn = 1'b1;
        tick();

        post(0, 7'h25, 1'b0, 8'h63);
        do_txn("wr0", 12, 1'b0, 0, 8'h00, 1'b0, -1);
        post(1, 7'h4C, 1'b1, 8'h00);
        do_txn("rd1", 20, 1'b0, 5, 8'hE3, 1'b0, -1);
        post(3, 7'h11, 1'b0, 8'hA5);
        do_txn("done_at_tmo_edge", TMO - 1, 1'b0, 0, 8'h00, 1'b0, -1);
        post(2, 7'h3A, 1'b1, 8'h00);
        do_txn("rd_timeout", TMO, 1'b0, 7, 8'h5C, 1'b0, -1);
        post(0, 7'h70, 1'b0, 8'h0F);
        do_txn("done_pre_high", 9, 1'b1, 0, 8'h00, 1'b0, -1);
        post(1, 7'h2B, 1'b1, 8'h00);
        do_txn("rd_same_cycle", 8, 1'b0, 8, 8'h96, 1'b0, -1);
        post(2, 7'h55, 1'b0, 8'hC3);
        do_txn("rst_mid_busy", 30, 1'b0, 0, 8'h00, 1'b0, 5);

        for (int i = 0; i < NREQ; i++) post(i, 7'(8'h10 + i), 1'(i), 8'(8'h80 + i));
        for (int i = 0; i < NREQ; i++) do_txn("all_four", 4 + i, 1'b0, 2, 8'(8'h40 + i), 1'b0, -1);

        post(0, 7'h01, 1'b0, 8'h11);
        post(2, 7'h02, 1'b0, 8'h22);
        do_txn("fair_a", 6, 1'b0, 0, 8'h00, 1'b1, -1);
        do_txn("fair_b", 6, 1'b0, 0, 8'h00, 1'b0, -1);
        do_txn("fair_c", 6, 1'b0, 0, 8'h00, 1'b0, -1);

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] == 1'b0 && $urandom_range(0, 1) == 1)
                    post(i, 7'($urandom), 1'($urandom), 8'($urandom));
            end
            if (req_valid == '0) post(int'($urandom_range(0, NREQ - 1)), 7'($urandom), 1'b1, 8'($urandom));
            sel = int'($urandom_range(0, 9));
            lat = (sel == 0) ? TMO : (sel == 1) ? TMO - 1 : int'($urandom_range(4, 40));
            do_txn("rand", lat, ($urandom_range(0, 3) == 0), int'($urandom_range(0, (lat < TMO) ? lat : TMO - 1)),
                   8'($urandom), ($urandom_range(0, 3) == 0), -1);
        end
        for (int i = 0; i < NREQ && req_valid != '0; i++) do_txn("drain", 10, 1'b0, 3, 8'($urandom), 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
